// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encodings, header nibble and byte width.
package uart_pkg;

   localparam int BYTE_W = 8;

   localparam logic [3:0] TAG_NIBBLE = 4'hA;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_TAG      = 3'd1;
   localparam logic [2:0] ST_TAG_WAIT = 3'd2;
   localparam logic [2:0] ST_LOAD     = 3'd3;
   localparam logic [2:0] ST_WAIT     = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_TAG      = ST_TAG,
      S_TAG_WAIT = ST_TAG_WAIT,
      S_LOAD     = ST_LOAD,
      S_WAIT     = ST_WAIT
   } state_t;

   function automatic logic [BYTE_W-1:0] tag_byte(
      input logic [3:0] id
   );
      return {TAG_NIBBLE, id};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid index
// after i_Ptr, wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_Valid,
   input  logic [IDX_W-1:0]   i_Ptr,
   output logic [IDX_W-1:0]   o_Idx,
   output logic               o_Any
);

   logic [IDX_W-1:0] k;

   // Scan farthest offset first so the nearest valid wins.
   always_comb begin
      o_Idx = '0;
      o_Any = 1'b0;
      k     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         k = IDX_W'((int'(i_Ptr) + i) % NUM_REQ);
         if (i_Valid[k]) begin
            o_Idx = k;
            o_Any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmit engine.
// Optional per-grant header byte: UART_TX_ARB_TAG_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IDX_W     = 2,
   parameter int MAX_BURST = 8
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst,
   input  logic [NUM_REQ-1:0]        i_Req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] i_Req_data,
   input  logic [NUM_REQ-1:0]        i_Req_last,
   output logic [NUM_REQ-1:0]        o_Req_ready,
   output logic [BYTE_W-1:0]         o_TX_byte,
   output logic                      o_TX_start,
   input  logic                      i_TX_done,
   output logic [IDX_W-1:0]          o_Grant_id,
   output logic                      o_Busy
);

   state_t state_q, state_d;

   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [7:0]        burst_q, burst_d;
   logic              last_q, last_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              start_q, start_d;

   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_Valid (i_Req_valid),
      .i_Ptr   (ptr_q),
      .o_Idx   (pick_idx),
      .o_Any   (pick_any)
   );

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Grant, pointer, burst and engine-facing registers.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         grant_q <= '0;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
         burst_q <= '0;
         last_q  <= 1'b0;
         byte_q  <= '0;
         start_q <= 1'b0;
      end else begin
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         byte_q  <= byte_d;
         start_q <= start_d;
      end
   end

   // Next state and datapath updates.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      last_d  = last_q;
      byte_d  = byte_q;
      start_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               burst_d = '0;
`ifdef UART_TX_ARB_TAG_EN
               state_d = S_TAG;
`else
               state_d = S_LOAD;
`endif
            end
         end
`ifdef UART_TX_ARB_TAG_EN
         S_TAG: begin
            byte_d  = tag_byte(4'(grant_q));
            start_d = 1'b1;
            state_d = S_TAG_WAIT;
         end
         S_TAG_WAIT: begin
            if (i_TX_done) state_d = S_LOAD;
         end
`endif
         S_LOAD: begin
            if (i_Req_valid[grant_q]) begin
               byte_d  = i_Req_data[{grant_q, 3'b000} +: BYTE_W];
               last_d  = i_Req_last[grant_q];
               if (burst_q != 8'hFF)
                  burst_d = burst_q + 8'd1;
               start_d = 1'b1;
               state_d = S_WAIT;
            end else begin
               ptr_d   = grant_q;
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (i_TX_done) begin
               if (last_q || burst_q == 8'(MAX_BURST)) begin
                  ptr_d   = grant_q;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Only the granted requester sees ready, and only in LOAD.
   always_comb begin
      o_Req_ready = '0;
      if (state_q == S_LOAD) o_Req_ready[grant_q] = 1'b1;
   end

   assign o_TX_byte  = byte_q;
   assign o_TX_start = start_q;
   assign o_Grant_id = grant_q;
   assign o_Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus random
// packet traffic against a packet-level arbitration model.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int IDX_W     = 2;
   localparam int MAX_BURST = 8;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  o_Req_ready;
   logic [7:0]  o_TX_byte;
   logic        o_TX_start;
   logic        i_TX_done;
   logic [1:0]  o_Grant_id;
   logic        o_Busy;

   logic eng_done = 1'b0;
   logic stray_done = 1'b0;
   assign i_TX_done = eng_done | stray_done;

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .IDX_W     (IDX_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_Req_valid (req_valid),
      .i_Req_data  (req_data),
      .i_Req_last  (req_last),
      .o_Req_ready (o_Req_ready),
      .o_TX_byte   (o_TX_byte),
      .o_TX_start  (o_TX_start),
      .i_TX_done   (i_TX_done),
      .o_Grant_id  (o_Grant_id),
      .o_Busy      (o_Busy)
   );

   initial forever #5 i_Clk = ~i_Clk;

   int n_checks = 0;
   int n_err = 0;

   // driver queues (bytes still to hand over)
   logic [7:0] rq_b[4][$];
   logic       rq_l[4][$];
   // model queues (same traffic, consumed by the model)
   logic [7:0] mq_b[4][$];
   logic       mq_l[4][$];
   logic [3:0] en = 4'hF;
   logic [3:0] acc = '0;
   int         m_ptr = NUM_REQ - 1;

   logic [7:0] exp_b[$];
   logic [1:0] exp_g[$];
   logic [7:0] log_b[$];
   logic [1:0] log_g[$];

   // behavioural engine: done pulses 10 cycles after start
   int         eng_cnt = 0;
   logic [7:0] eng_held = '0;
   int         hold_viol = 0;

   initial forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
         eng_cnt  = 0;
         eng_done = 1'b0;
      end else begin
         eng_done = 1'b0;
         if (eng_cnt > 0) begin
            if (o_TX_byte !== eng_held) hold_viol++;
            if (o_TX_start) hold_viol++;
            eng_cnt--;
            if (eng_cnt == 0) eng_done = 1'b1;
         end else if (o_TX_start) begin
            eng_held = o_TX_byte;
            eng_cnt  = 10;
            log_b.push_back(o_TX_byte);
            log_g.push_back(o_Grant_id);
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int r = 0; r < NUM_REQ; r++) begin
         if (rq_b[r].size() > 0 && en[r]) begin
            req_valid[r]       = 1'b1;
            req_data[8*r +: 8] = rq_b[r][0];
            req_last[r]        = rq_l[r][0];
         end else begin
            req_valid[r]       = 1'b0;
            req_data[8*r +: 8] = 8'h00;
            req_last[r]        = 1'b0;
         end
      end
   endtask

   // one clock: retire handshakes, redrive, land on negedge
   task automatic step();
      @(posedge i_Clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (acc[r]) begin
            void'(rq_b[r].pop_front());
            void'(rq_l[r].pop_front());
         end
      end
      drive();
      @(negedge i_Clk);
      acc = req_valid & o_Req_ready;
   endtask

   task automatic add_byte(input int r,
                           input logic [7:0] b,
                           input logic l);
      rq_b[r].push_back(b);
      rq_l[r].push_back(l);
      mq_b[r].push_back(b);
      mq_l[r].push_back(l);
   endtask

   task automatic clear_all();
      for (int r = 0; r < NUM_REQ; r++) begin
         rq_b[r].delete();
         rq_l[r].delete();
         mq_b[r].delete();
         mq_l[r].delete();
      end
      log_b.delete();
      log_g.delete();
      exp_b.delete();
      exp_g.delete();
      acc = '0;
   endtask

   function automatic bit all_empty();
      for (int r = 0; r < NUM_REQ; r++)
         if (rq_b[r].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic reset_dut();
      i_Rst = 1'b1;
      clear_all();
      drive();
      step();
      step();
      i_Rst = 1'b0;
      m_ptr = NUM_REQ - 1;
   endtask

   // packet-level arbitration: every requester with data
   // left is a candidate; grant holds for up to MAX_BURST
   // bytes or until last.
   task automatic model_build();
      int g;
      int n;
      int r;
      logic l;
      logic [7:0] b;
      while (1) begin
         g = -1;
         for (int k = 1; k <= NUM_REQ; k++) begin
            r = (m_ptr + k) % NUM_REQ;
            if (g < 0 && mq_b[r].size() > 0) g = r;
         end
         if (g < 0) break;
`ifdef UART_TX_ARB_TAG_EN
         exp_b.push_back({4'hA, 4'(g)});
         exp_g.push_back(2'(g));
`endif
         n = 0;
         do begin
            b = mq_b[g].pop_front();
            l = mq_l[g].pop_front();
            exp_b.push_back(b);
            exp_g.push_back(2'(g));
            n++;
         end while (!l && n < MAX_BURST);
         m_ptr = g;
      end
   endtask

   task automatic run_check(input string tag,
                            input int budget);
      int t;
      int m;
      model_build();
      t = 0;
      while (!(log_b.size() >= exp_b.size() &&
               !o_Busy && all_empty()) && t < budget) begin
         step();
         t++;
      end
      chk({tag, " in-time"}, 32'(t < budget), 32'd1);
      chk({tag, " count"}, 32'(log_b.size()),
          32'(exp_b.size()));
      m = (log_b.size() < exp_b.size()) ?
          log_b.size() : exp_b.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s byte%0d", tag, i),
             32'(log_b[i]), 32'(exp_b[i]));
         chk($sformatf("%s grant%0d", tag, i),
             32'(log_g[i]), 32'(exp_g[i]));
      end
      chk({tag, " hold"}, 32'(hold_viol), 32'd0);
      log_b.delete();
      log_g.delete();
      exp_b.delete();
      exp_g.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ready"}, 32'(o_Req_ready), 32'd0);
      chk({tag, " start"}, 32'(o_TX_start), 32'd0);
      chk({tag, " byte"}, 32'(o_TX_byte), 32'd0);
      chk({tag, " grant"}, 32'(o_Grant_id), 32'd0);
      chk({tag, " busy"}, 32'(o_Busy), 32'd0);
   endtask

   initial begin
      int t;
      int np;
      int len;

      // T0: reset values
      @(negedge i_Clk);
      reset_dut();
      chk_reset_vals("t0");

      // T1: single byte, latency
      add_byte(0, 8'h55, 1'b1);
`ifndef UART_TX_ARB_TAG_EN
      step();
      chk("t1 ready N", 32'(o_Req_ready), 32'd0);
      chk("t1 busy N", 32'(o_Busy), 32'd0);
      step();
      chk("t1 ready N+1", 32'(o_Req_ready), 32'h1);
      chk("t1 grant N+1", 32'(o_Grant_id), 32'd0);
      chk("t1 start N+1", 32'(o_TX_start), 32'd0);
      step();
      chk("t1 start N+2", 32'(o_TX_start), 32'd1);
      chk("t1 byte N+2", 32'(o_TX_byte), 32'h55);
      chk("t1 ready N+2", 32'(o_Req_ready), 32'd0);
      for (int k = 0; k < 10; k++) step();
      chk("t1 busy at done", 32'(o_Busy), 32'd1);
      step();
      chk("t1 idle after done", 32'(o_Busy), 32'd0);
`endif
      run_check("t1", 200);

      // T2: four 1-byte packets plus a second from req0
      reset_dut();
      add_byte(0, 8'h10, 1'b1);
      add_byte(0, 8'h11, 1'b1);
      add_byte(1, 8'h20, 1'b1);
      add_byte(2, 8'h30, 1'b1);
      add_byte(3, 8'h40, 1'b1);
      run_check("t2", 500);

      // T3: 10-byte packet split by MAX_BURST
      for (int k = 0; k < 10; k++)
         add_byte(1, 8'(8'hB0 + k), k == 9);
      for (int k = 0; k < 3; k++)
         add_byte(2, 8'(8'hC0 + k), k == 2);
      run_check("t3", 1000);

`ifndef UART_TX_ARB_TAG_EN
      // T4: req3 abandons in LOAD
      add_byte(3, 8'h77, 1'b1);
      step();
      chk("t4 busy N", 32'(o_Busy), 32'd0);
      step();
      chk("t4 ready LOAD", 32'(o_Req_ready), 32'h8);
      chk("t4 grant LOAD", 32'(o_Grant_id), 32'd3);
      en[3] = 1'b0;
      drive();
      acc = req_valid & o_Req_ready;
      step();
      chk("t4 idle", 32'(o_Busy), 32'd0);
      chk("t4 no start", 32'(o_TX_start), 32'd0);
      step();
      chk("t4 no log", 32'(log_b.size()), 32'd0);
      clear_all();
      en[3] = 1'b1;
      m_ptr = 3;
      add_byte(0, 8'hA0, 1'b1);
      add_byte(3, 8'hB3, 1'b1);
      run_check("t4 next", 500);
`endif

      // T5: reset 3 cycles into WAIT, stray done
      add_byte(0, 8'hC3, 1'b1);
      t = 0;
      while (!(o_TX_start && o_TX_byte == 8'hC3) && t < 50) begin
         step();
         t++;
      end
      chk("t5 start seen", 32'(t < 50), 32'd1);
      step();
      step();
      step();
      i_Rst = 1'b1;
      step();
      chk_reset_vals("t5 rst");
      step();
      i_Rst = 1'b0;
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      step();
      chk("t5 stray busy", 32'(o_Busy), 32'd0);
      chk("t5 stray start", 32'(o_TX_start), 32'd0);
      clear_all();
      m_ptr = NUM_REQ - 1;

`ifdef UART_TX_ARB_TAG_EN
      // T6: header byte then payload
      reset_dut();
      add_byte(2, 8'h41, 1'b1);
      run_check("t6", 200);
`endif

      // T7: random packets on all requesters
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 12);
               for (int k = 0; k < len; k++)
                  add_byte(r, 8'($urandom), k == len - 1);
            end
         end
         run_check($sformatf("t7 r%0d", rnd), 8000);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
